uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
UART serial transmitter that produces the serial stream consumed by the existing UART receive top (its `ser_in`).
- Accepts one byte per Send/Sent handshake.
- Frame format: 1 start bit, 8 data bits LSB first, 1 odd-parity bit, 1 stop bit.
- Sits in the paired "transmit" top, driving the board tx pin; source is the switches and the Send button.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock rate in Hz
BAUD_RATE, 19_200, serial bit rate; BAUD_DIV = CLK_FREQUENCY/BAUD_RATE (5208 at defaults), integer-truncated, must be >= 2
PARITY_ODD, 1, 1 = odd parity (parity bit = ~^din); 0 = even parity (parity bit = ^din)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
Send  input  1  request to transmit din; level-sensitive, held until Sent observed
din  input  8  byte to transmit; sampled only on the IDLE->START transition
Sent  output  1  completion acknowledge; high from end of stop bit until Send is low
tx_out  output  1  serial line; idle/mark = 1; registered, glitch-free
busy  output  1  high in START, DATA, PARITY and STOP

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low.
- Reset values: tx_out=1, Sent=0, busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0. Asserting reset mid-frame forces tx_out=1 immediately (asynchronously) and abandons the frame.
- States are IDLE, START, DATA, PARITY, STOP, ACK.
- IDLE:
  - If Send=1 at edge k: latch din into shift register, latch parity bit, go to START.
  - tx_out goes 0 from edge k (visible after edge k), busy=1.
- Baud timer: clears on entry to each bit state and counts 0..BAUD_DIV-1. The state advances when the count reaches BAUD_DIV-1, so every bit is exactly BAUD_DIV cycles on tx_out.
- START: tx_out=0 for BAUD_DIV cycles, then DATA with bit index=0.
- DATA:
  - tx_out = shreg[0], bits sent LSB first.
  - At each bit end: shift right and increment the index.
  - After index 7 completes, go to PARITY.
- PARITY: tx_out = latched parity bit for BAUD_DIV cycles, then STOP.
- STOP: tx_out=1 for BAUD_DIV cycles, then ACK.
- ACK:
  - Sent=1, busy=0, tx_out=1.
  - Leave to IDLE on the first edge where Send=0.
  - If Send is already 0 on entry, Sent is high for exactly 1 cycle.
- Frame length: 11*BAUD_DIV cycles from the first tx_out=0 to the end of the stop bit. The next start bit can begin no sooner than 2 cycles after the stop bit ends (ACK, then IDLE).
- Send changes mid-frame are ignored; the frame always completes. din changes after latch are ignored.
- Send held continuously: exactly one frame per handshake; no retransmit until Send drops and rises again.
- Sent=0 in every state except ACK. tx_out is never X after reset.

Decomposition:
- Shared package `uart_pkg`:
  - tx state enum typedef (IDLE, START, DATA, PARITY, STOP, ACK).
  - DATA_BITS=8 and FRAME_BITS=11.
  - Function baud_div(clk_freq, baud).
  - Function parity_bit(data, odd).
  - The receiver reuses the package constants and parity function.
- One sub-module, `uart_baud_timer`: parameter DIV; inputs clk, reset, clr; output tick (one-cycle pulse at count DIV-1). The transmitter keeps the FSM, shift register and bit index.

Test Plan:
- Bench parameters CLK_FREQUENCY=1000, BAUD_RATE=100, so BAUD_DIV=10.
- Reset held low 5 cycles, Send=0 -> tx_out=1, Sent=0, busy=0 throughout; reset asserted mid-frame returns tx_out=1 the same cycle.
- din=8'h41, Send pulse held until Sent -> tx_out 10-cycle bits: 0,1,0,0,0,0,0,1,0,1(parity),1(stop); Sent rises at cycle 110 after the start edge; receiver model decodes 0x41 with no parity error.
- din=8'h01 then 8'hFF -> parity bits 0 and 1 respectively; din=8'h00 -> parity bit 1. Repeat with PARITY_ODD=0 -> 1, 0, 0.
- Send held high 300 cycles -> exactly one frame; Sent stays high until Send drops, then goes low 1 cycle later; busy=0 during ACK.
- Send dropped at cycle 30 of the frame and din changed to 8'hAA -> frame still carries the original 0x41 to completion; Sent is high for exactly 1 cycle.
- Loopback: tx_out wired to the receive top's ser_in; bytes 0x00, 0x55, 0xA5, 0xFF back-to-back -> rxData matches each byte, parityErr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// helpers used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop,
    TxAck
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;

  // Clock cycles per serial bit, integer-truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Parity bit that makes the total count of ones in {data, parity} odd (odd=1)
  // or even (odd=0).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick on the last count of each
// bit. Holding clr keeps the count at zero so a new bit starts cleanly.
module uart_baud_timer #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_count;

  // Free-running bit counter, wraps after the last count of a bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit,
// with a level Send / Sent handshake. tx_out is driven straight from a flop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter bit          PARITY_ODD    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Send,
  input  logic [7:0] din,
  output logic       Sent,
  output logic       tx_out,
  output logic       busy
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);

  tx_state_e  r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_bit_idx;
  logic       r_parity;
  logic       r_tx;
  logic       r_sent;
  logic       r_busy;

  logic w_tick;
  logic w_clr;

  // Timer is parked at zero outside the bit-carrying states so the start bit
  // gets a full period from the Send edge.
  assign w_clr = (r_state == TxIdle) || (r_state == TxAck);

  uart_baud_timer #(
    .DIV (BAUD_DIV)
  ) u_baud_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Frame sequencer with registered line, busy and acknowledge outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= TxIdle;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_sent    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        TxIdle: begin
          if (Send) begin
            r_shreg  <= din;
            r_parity <= parity_bit(din, PARITY_ODD);
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= TxStart;
          end
        end
        TxStart: begin
          if (w_tick) begin
            r_bit_idx <= '0;
            r_tx      <= r_shreg[0];
            r_state   <= TxData;
          end
        end
        TxData: begin
          if (w_tick) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= r_parity;
              r_state <= TxParity;
            end else begin
              r_tx <= r_shreg[1];
            end
          end
        end
        TxParity: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= TxStop;
          end
        end
        TxStop: begin
          if (w_tick) begin
            r_sent  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= TxAck;
          end
        end
        TxAck: begin
          // Hold the acknowledge until the requester releases Send.
          if (!Send) begin
            r_sent  <= 1'b0;
            r_state <= TxIdle;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_sent  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= TxIdle;
        end
      endcase
    end
  end

  assign tx_out = r_tx;
  assign Sent   = r_sent;
  assign busy   = r_busy;

endmodule
